// File: rtl/key_expansion_iter_if.sv
// Key-load / round-key-read bus of the iterative AES key expander.
// KEY_EXP_STREAM_EN adds the registered round-key stream outputs.
interface key_expansion_iter_if #(
    parameter int NK = 4
);
    logic              start_i;
    logic [32*NK-1:0]  key_in_i;
    logic              busy_o;
    logic              done_o;
    logic [3:0]        rd_round_i;
    logic [127:0]      rd_key_o;
`ifdef KEY_EXP_STREAM_EN
    logic              rk_valid_o;
    logic [3:0]        rk_round_o;
    logic [127:0]      rk_data_o;
`endif

    modport master (
        output start_i, key_in_i, rd_round_i,
        input  busy_o, done_o, rd_key_o
`ifdef KEY_EXP_STREAM_EN
        , input rk_valid_o, rk_round_o, rk_data_o
`endif
    );

    modport slave (
        input  start_i, key_in_i, rd_round_i,
        output busy_o, done_o, rd_key_o
`ifdef KEY_EXP_STREAM_EN
        , output rk_valid_o, rk_round_o, rk_data_o
`endif
    );
endinterface

// File: rtl/key_expansion_iter.sv
// Sequential AES-128/192/256 key expander: one schedule word per clock into a register file.
// Optional KEY_EXP_STREAM_EN streams each round key out as soon as its four words exist.
module key_exp_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX[{a_i, 3'b000} +: 8];
endmodule

module key_expansion_iter #(
    parameter int NK = 4
) (
    input  logic                clk,
    input  logic                rst,
    key_expansion_iter_if.slave bus
);
    localparam int NR = NK + 6;
    localparam int W  = 4 * (NR + 1);
    localparam logic [5:0] NK6   = 6'(NK);
    localparam logic [5:0] LAST  = 6'(W - 1);
    localparam logic [2:0] KLAST = 3'(NK - 1);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t      state_q, state_d;
    logic [31:0] w_q [W];
    logic [5:0]  i_q, i_d;
    logic [2:0]  k_q, k_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;
    logic        load, wr_en;
    logic [5:0]  prev_idx, old_idx, rd_base;
    logic [31:0] prev_w, sub_in, sub_out, t, w_new;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            i_q     <= '0;
            k_q     <= '0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            k_q     <= k_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        k_d     = k_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        load    = 1'b0;
        wr_en   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start_i) begin
                    load    = 1'b1;
                    state_d = EXPAND;
                    i_d     = NK6;
                    k_d     = 3'd0;
                    rcon_d  = 8'h01;
                end
            end
            EXPAND: begin
                wr_en = 1'b1;
                i_d   = i_q + 6'd1;
                k_d   = (k_q == KLAST) ? 3'd0 : k_q + 3'd1;
                // rcon only advances on the words that consume it
                if (k_q == 3'd0)
                    rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
                if (i_q == LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Indices are parked at 0 while idle so the reads never leave the array.
    always_comb begin
        prev_idx = (state_q == EXPAND) ? i_q - 6'd1 : 6'd0;
        old_idx  = (state_q == EXPAND) ? i_q - NK6  : 6'd0;
        prev_w   = w_q[prev_idx];
        sub_in   = (k_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;
    end

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        key_exp_sbox u_sbox (.a_i(sub_in[8*b +: 8]), .y_o(sub_out[8*b +: 8]));
    end

    always_comb begin
        t = prev_w;
        if (k_q == 3'd0)
            t = sub_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && k_q == 3'd4)
            t = sub_out;
        w_new = w_q[old_idx] ^ t;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < W; j++) w_q[j] <= '0;
        end else if (load) begin
            for (int j = 0; j < NK; j++) w_q[j] <= bus.key_in_i[32*(NK-1-j) +: 32];
        end else if (wr_en) begin
            w_q[i_q] <= w_new;
        end
    end

    always_comb begin
        rd_base      = {bus.rd_round_i, 2'b00};
        bus.rd_key_o = '0;
        if (bus.rd_round_i <= 4'(NR))
            bus.rd_key_o = {w_q[rd_base], w_q[rd_base + 6'd1],
                            w_q[rd_base + 6'd2], w_q[rd_base + 6'd3]};
    end

    assign bus.busy_o = (state_q == EXPAND);
    assign bus.done_o = done_q;

`ifdef KEY_EXP_STREAM_EN
    logic [3:0]   r_q, r_d;
    logic         rk_valid_q, rk_valid_d;
    logic [3:0]   rk_round_q, rk_round_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [5:0]   r_base;
    logic [31:0]  rw [4];

    // A round is ready once its last word is being written this edge; that
    // word is taken from w_new since it is not in the register file yet.
    always_comb begin
        r_d        = r_q;
        rk_valid_d = 1'b0;
        rk_round_d = rk_round_q;
        rk_data_d  = rk_data_q;
        r_base     = {r_q, 2'b00};
        for (int m = 0; m < 4; m++) rw[m] = '0;
        if (load) begin
            rk_valid_d = 1'b1;
            rk_round_d = 4'd0;
            rk_data_d  = bus.key_in_i[32*NK-1 -: 128];
            r_d        = 4'd1;
        end else if (wr_en && r_q <= 4'(NR) && (r_base + 6'd3) <= i_q) begin
            for (int m = 0; m < 4; m++)
                rw[m] = ((r_base + 6'(m)) == i_q) ? w_new : w_q[r_base + 6'(m)];
            rk_valid_d = 1'b1;
            rk_round_d = r_q;
            rk_data_d  = {rw[0], rw[1], rw[2], rw[3]};
            r_d        = r_q + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q        <= '0;
            rk_valid_q <= 1'b0;
            rk_round_q <= '0;
            rk_data_q  <= '0;
        end else begin
            r_q        <= r_d;
            rk_valid_q <= rk_valid_d;
            rk_round_q <= rk_round_d;
            rk_data_q  <= rk_data_d;
        end
    end

    assign bus.rk_valid_o = rk_valid_q;
    assign bus.rk_round_o = rk_round_q;
    assign bus.rk_data_o  = rk_data_q;
`endif
endmodule

// File: tb/tb_key_expansion_iter.sv
// Directed bench for key_expansion_iter: FIPS-197 schedules for NK=4/6/8, busy/back-to-back
// start, async reset mid-expansion, and the round-key stream when KEY_EXP_STREAM_EN is set.
module tb_key_expansion_iter;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   sel;
    logic [255:0] key;
    logic [3:0]   rd_round;
    logic         done_m, busy_m;
    logic [127:0] rdk_m;
    int total = 0;
    int bad   = 0;
    int pcount = 0;
    int n;

    localparam logic [127:0] K128 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [191:0] K192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
    localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    key_expansion_iter_if #(.NK(4)) if4 ();
    key_expansion_iter_if #(.NK(6)) if6 ();
    key_expansion_iter_if #(.NK(8)) if8 ();

    key_expansion_iter #(.NK(4)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    key_expansion_iter #(.NK(6)) u6 (.clk(clk), .rst(rst), .bus(if6.slave));
    key_expansion_iter #(.NK(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

    assign if4.start_i    = start && (sel == 2'd0);
    assign if6.start_i    = start && (sel == 2'd1);
    assign if8.start_i    = start && (sel == 2'd2);
    assign if4.key_in_i   = key[255:128];
    assign if6.key_in_i   = key[255:64];
    assign if8.key_in_i   = key;
    assign if4.rd_round_i = rd_round;
    assign if6.rd_round_i = rd_round;
    assign if8.rd_round_i = rd_round;

    always_comb begin
        unique case (sel)
            2'd0:    begin done_m = if4.done_o; busy_m = if4.busy_o; rdk_m = if4.rd_key_o; end
            2'd1:    begin done_m = if6.done_o; busy_m = if6.busy_o; rdk_m = if6.rd_key_o; end
            default: begin done_m = if8.done_o; busy_m = if8.busy_o; rdk_m = if8.rd_key_o; end
        endcase
    end

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge and sample 1ns later; also audits the NK=8 stream.
    task automatic tick();
`ifdef KEY_EXP_STREAM_EN
        logic [3:0] save;
`endif
        @(posedge clk);
        #1;
`ifdef KEY_EXP_STREAM_EN
        if (if8.rk_valid_o) begin
            check("rk_round", 128'(if8.rk_round_o), 128'(pcount));
            save     = rd_round;
            rd_round = if8.rk_round_o;
            #1;
            check("rk_data", if8.rk_data_o, if8.rd_key_o);
            if (if8.rk_round_o == 4'd14) check("rk_last_done", 128'(if8.done_o), 128'd1);
            rd_round = save;
            pcount++;
        end
`endif
    endtask

    task automatic go(input logic [1:0] s, input logic [255:0] k);
        sel   = s;
        key   = k;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int n0, output int cnt);
        cnt = n0;
        do begin
            tick();
            cnt++;
        end while (!done_m && cnt < 200);
    endtask

    task automatic rd(input logic [3:0] r, output logic [127:0] v);
        rd_round = r;
        #1;
        v = rdk_m;
    endtask

    initial begin
        logic [127:0] v;
        rst = 1'b0; start = 1'b0; sel = 2'd0; key = '0; rd_round = '0;
        #1 rst = 1'b1;
        #3;
        check("rst_busy4", 128'(if4.busy_o), 128'd0);
        check("rst_done4", 128'(if4.done_o), 128'd0);
        check("rst_busy8", 128'(if8.busy_o), 128'd0);
        for (int r = 0; r < 15; r++) begin
            rd_round = 4'(r);
            #1;
            check("rst_rd4", if4.rd_key_o, 128'h0);
            check("rst_rd6", if6.rd_key_o, 128'h0);
            check("rst_rd8", if8.rd_key_o, 128'h0);
        end
`ifdef KEY_EXP_STREAM_EN
        check("rst_rkv", 128'(if8.rk_valid_o), 128'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        tick();

        // AES-128
        go(2'd0, {K128, 128'h0});
        check("busy128", 128'(busy_m), 128'd1);
        wait_done(0, n);
        check("lat128", 128'(n), 128'd40);
        check("busy_at_done", 128'(busy_m), 128'd0);
        rd(4'd0, v);  check("k128_r0", v, K128);
        rd(4'd1, v);  check("k128_r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd2, v);  check("k128_r2", v, 128'hf2c295f27a96b9435935807a7359f67f);
        rd(4'd10, v); check("k128_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        rd(4'd11, v); check("k128_r11", v, 128'h0);
        rd(4'd15, v); check("k128_r15", v, 128'h0);
        tick();

        // start while busy is ignored; start in done cycle is accepted
        go(2'd0, {K128, 128'h0});
        repeat (9) tick();
        key   = {256{1'b1}};
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(10, n);
        check("lat_busy", 128'(n), 128'd40);
        rd(4'd10, v); check("busy_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        key   = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_busy", 128'(busy_m), 128'd1);
        wait_done(0, n);
        check("lat_b2b", 128'(n), 128'd40);
        rd(4'd1, v); check("zero_r1", v, 128'h62636363626363636263636362636363);
        rd(4'd2, v); check("zero_r2", v, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
        tick();

        // AES-192
        go(2'd1, {K192, 64'h0});
        wait_done(0, n);
        check("lat192", 128'(n), 128'd46);
        rd(4'd1, v);  check("k192_r1", v, 128'h62f8ead2522c6b7bfe0c91f72402f5a5);
        rd(4'd12, v); check("k192_r12", v, 128'he98ba06f448c773c8ecc720401002202);
        rd(4'd13, v); check("k192_r13", v, 128'h0);
        tick();

        // AES-256 (stream audited inside tick)
        pcount = 0;
        go(2'd2, K256);
        wait_done(0, n);
        check("lat256", 128'(n), 128'd52);
        rd(4'd1, v);  check("k256_r1", v, 128'h1f352c073b6108d72d9810a30914dff4);
        rd(4'd2, v);  check("k256_r2", v, 128'h9ba354118e6925afa51a8b5f2067fcde);
        rd(4'd14, v); check("k256_r14", v, 128'hfe4890d1e6188d0b046df344706c631e);
        tick();
`ifdef KEY_EXP_STREAM_EN
        check("rk_count", 128'(pcount), 128'd15);
`endif

        // async reset mid-expansion
        go(2'd0, {K128, 128'h0});
        repeat (20) tick();
        check("mid_busy", 128'(busy_m), 128'd1);
        rst = 1'b1;
        #1;
        check("arst_busy", 128'(busy_m), 128'd0);
        check("arst_done", 128'(done_m), 128'd0);
        for (int r = 0; r < 11; r++) begin
            rd(4'(r), v);
            check("arst_rd", v, 128'h0);
        end
`ifdef KEY_EXP_STREAM_EN
        check("arst_rkv", 128'(if8.rk_valid_o), 128'd0);
`endif
        rst = 1'b0;
        tick();
        go(2'd0, {K128, 128'h0});
        wait_done(0, n);
        check("lat_post_rst", 128'(n), 128'd40);
        rd(4'd1, v);  check("post_r1", v, 128'ha0fafe1788542cb123a339392a6c7605);
        rd(4'd10, v); check("post_r10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/key_expansion_iter.md
# key_expansion_iter

Iterative, parametrised AES key expander covering AES-128/192/256. It replaces the unrolled combinational expansion with a sequential engine that computes one 32-bit schedule word per clock and keeps every round key in an internal register file. It sits between key load and the round datapath: the cipher core reads round keys by index once `done` fires.

## Interface
- `NK`, default 4: key length in 32-bit words; legal values 4, 6, 8 (NR = NK+6; total words W = 4·(NR+1) = 44/52/60).
- `clk` in 1: the one clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `start` in 1: request expansion of `key_in`; sampled only while `busy`=0.
- `key_in` in 32·NK: cipher key, word 0 in the most significant 32 bits, FIPS-197 byte order (byte 0 in the MSB).
- `busy` out 1: expansion in progress.
- `done` out 1: one-cycle pulse when the schedule is complete.
- `rd_round` in 4: round-key index 0..NR.
- `rd_key` out 128: combinational read of round key `rd_round` = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, w[4r] in bits 127:96.

## Operation
- State machine: IDLE and EXPAND.
  - IDLE with `start`=1: at that edge write w[0..NK-1] from `key_in`, set i=NK, rcon=8'h01, k=0 (i mod NK), and go to EXPAND.
  - EXPAND: each cycle compute t = w[i-1].
    - If k==0: t = SubWord(RotWord(t)) ^ {rcon, 24'h0}, then rcon <= xtime(rcon) (8'h80 becomes 8'h1b).
    - If NK==8 and k==4: t = SubWord(t).
    - Write w[i] = w[i-NK] ^ t, i++, k = (k==NK-1) ? 0 : k+1.
    - When i == W-1 is written, go to IDLE and set `done`=1 for that one cycle.
- No division or modulo hardware. k is a wrap counter, and rcon is advanced with xtime.
- SubWord uses four instances of an internal 256-entry FIPS-197 S-box table.
- `start` while `busy`=1 is ignored. The key and schedule in progress are unaffected.
- `start` in the same cycle as `done`: accepted. A new expansion begins, and the old schedule is progressively overwritten.
- `rd_key` for rounds not yet written returns the previous contents. `rd_round` > NR returns 128'h0.
- Reset, including mid-expansion: state becomes IDLE, `busy`=0, `done`=0, all w[] cleared to 0, i=0, rcon=8'h01.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_key`=0 for every index.
- `busy` goes high the cycle after the accepting edge E. It stays high through the last EXPAND cycle and falls in the same cycle that `done` is high.
- Latency from the `start` edge E to the `done` cycle is W−NK edges:
  - NK=4: `done` high between edges E+40 and E+41.
  - NK=6: 46 edges.
  - NK=8: 52 edges.
- All round keys are valid on `rd_key` from the `done` cycle onward, until the next accepted `start`.

## Configuration
- `KEY_EXP_STREAM_EN` defined: adds three outputs.
  - Ports: `rk_valid` out 1, `rk_round` out 4, `rk_data` out 128. All are registered and reset to 0.
  - Emission counter r starts at 0 on an accepted `start`.
  - In any cycle where words up to 4r+3 are written and r ≤ NR, emit round r for one cycle, then r++. At most one round is emitted per cycle.
  - Round 0 is emitted the cycle after E. Round NR is emitted in the `done` cycle.
  - NK=8: round 1 follows in the cycle after round 0.
- `KEY_EXP_STREAM_EN` not defined: these ports are absent, and the emission logic is not built.

## Test plan
- AES-128 (NK=4):
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required response: `done` exactly 40 edges after E. `rd_round`=1 gives a0fafe1788542cb123a339392a6c7605. `rd_round`=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
- AES-192 (NK=6):
  - Stimulus: key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b.
  - Required response: `done` at E+46. Round 12 = e98ba06f448c773c8ecc720401002202.
- AES-256 (NK=8):
  - Stimulus: key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4.
  - Required response: `done` at E+52. Round 14 = fe4890d1e6188d0b046df344706c631e.
- Busy and back-to-back start (NK=4):
  - Pulse `start` with a different key at E+10: no effect, and the round 10 value is unchanged.
  - Assert `start` in the `done` cycle with the all-zero key: the second `done` arrives 40 edges later, with round 1 = 62636363626363636263636362636363.
- Async reset mid-expansion (NK=4):
  - Assert `rst` at E+20, between edges: `busy`/`done` drop immediately, and every `rd_key` reads 0.
  - A fresh `start` then completes normally.
- Stream (NK=8, `KEY_EXP_STREAM_EN`):
  - Required response: exactly 15 `rk_valid` pulses with `rk_round` 0..14 in order. Each `rk_data` matches `rd_key`. The last pulse coincides with `done`.
